// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, sample type, serializer FSM states.
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } ser_state_t;

endpackage

// File: rtl/serializer_lrck_edge.sv
// LRCK edge detector: registers the previous level and flags frame-start and mid-frame edges.
module lrck_edge #(
  parameter bit LEFT_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic lrck,
  output logic start_edge,
  output logic mid_edge
);

  logic lr_prev;

  // Reset to the left level so a reset released mid-left cannot fake a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lr_prev <= LEFT_LEVEL;
    else     lr_prev <= lrck;
  end

  assign start_edge = (lrck == LEFT_LEVEL) && (lr_prev != LEFT_LEVEL);
  assign mid_edge   = (lrck != LEFT_LEVEL) && (lr_prev == LEFT_LEVEL);

endmodule

// File: rtl/serializer.sv
// Stereo DAC serializer: one-entry holding buffer feeding an MSB-first shifter framed by DACLRCK.
// Build option SERIALIZER_UNDERRUN_ZERO_EN: underrun frames send silence instead of repeating.
module serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
  parameter bit LEFT_LEVEL = 1'b1
) (
  input  logic                       BCLK,
  input  logic                       RESET,
  input  logic                       DACLRCK,
  input  logic signed [SAMPLE_W-1:0] leftSample,
  input  logic signed [SAMPLE_W-1:0] rightSample,
  input  logic                       sampleValid,
  output logic                       sampleReady,
  output logic                       DACDAT,
  output logic                       underrun
);

  localparam int CW = $clog2(SAMPLE_W + 1);

  ser_state_t          state;
  logic [CW-1:0]       bit_cnt;
  logic [SAMPLE_W-1:0] buf_l, buf_r, sh_l, sh_r, last_l, last_r, load_l, load_r;
  logic                buf_full, accept, load_under;
  logic                start_edge, mid_edge;

  lrck_edge #(.LEFT_LEVEL(LEFT_LEVEL)) u_edge (
    .clk       (BCLK),
    .rst       (RESET),
    .lrck      (DACLRCK),
    .start_edge(start_edge),
    .mid_edge  (mid_edge)
  );

  assign sampleReady = !buf_full;
  assign accept      = sampleValid && !buf_full;

  // Pair chosen for a frame: buffered, else bypassed incoming, else underrun fill.
  always_comb begin
    load_under = 1'b0;
    load_l     = buf_l;
    load_r     = buf_r;
    if (!buf_full) begin
      if (accept) begin
        load_l = leftSample;
        load_r = rightSample;
      end else begin
        load_under = 1'b1;
`ifdef SERIALIZER_UNDERRUN_ZERO_EN
        load_l = '0;
        load_r = '0;
`else
        load_l = last_l;
        load_r = last_r;
`endif
      end
    end
  end

  always_ff @(posedge BCLK or posedge RESET) begin
    if (RESET) begin
      state    <= SYNC;
      bit_cnt  <= '0;
      buf_l    <= '0;
      buf_r    <= '0;
      buf_full <= 1'b0;
      sh_l     <= '0;
      sh_r     <= '0;
      last_l   <= '0;
      last_r   <= '0;
      DACDAT   <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (start_edge) begin
        state    <= LEFT;
        sh_l     <= load_l << 1;
        sh_r     <= load_r;
        last_l   <= load_l;
        last_r   <= load_r;
        DACDAT   <= load_l[SAMPLE_W-1];
        bit_cnt  <= CW'(1);
        underrun <= load_under;
        buf_full <= 1'b0;
      end else begin
        if (accept) begin
          buf_l    <= leftSample;
          buf_r    <= rightSample;
          buf_full <= 1'b1;
        end
        case (state)
          SYNC: DACDAT <= 1'b0;
          LEFT: begin
            if (mid_edge) begin
              state   <= RIGHT;
              DACDAT  <= sh_r[SAMPLE_W-1];
              sh_r    <= sh_r << 1;
              bit_cnt <= CW'(1);
            end else if (bit_cnt < CW'(SAMPLE_W)) begin
              DACDAT  <= sh_l[SAMPLE_W-1];
              sh_l    <= sh_l << 1;
              bit_cnt <= bit_cnt + CW'(1);
            end else begin
              DACDAT <= 1'b0;
            end
          end
          RIGHT: begin
            if (bit_cnt < CW'(SAMPLE_W)) begin
              DACDAT  <= sh_r[SAMPLE_W-1];
              sh_r    <= sh_r << 1;
              bit_cnt <= bit_cnt + CW'(1);
            end else begin
              DACDAT <= 1'b0;
            end
          end
          default: begin
            state  <= SYNC;
            DACDAT <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: scoreboard of accepted pairs checked bit-by-bit on DACDAT.
module tb_serializer;
  import audio_pkg::*;

  localparam int W = audio_pkg::SAMPLE_W;

  logic          BCLK = 1'b0;
  logic          RESET = 1'b1;
  logic          DACLRCK = 1'b0;
  logic [W-1:0]  leftSample = '0;
  logic [W-1:0]  rightSample = '0;
  logic          sampleValid = 1'b0;
  logic          sampleReady, DACDAT, underrun;

  int            errors = 0;
  int            checks = 0;
  logic [2*W-1:0] src_q[$];
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]  last_l = '0, last_r = '0;
  logic          rdy_at_start;

  serializer dut (
    .BCLK       (BCLK),
    .RESET      (RESET),
    .DACLRCK    (DACLRCK),
    .leftSample (leftSample),
    .rightSample(rightSample),
    .sampleValid(sampleValid),
    .sampleReady(sampleReady),
    .DACDAT     (DACDAT),
    .underrun   (underrun)
  );

  initial forever #5 BCLK = ~BCLK;

  // Source: offers queued pairs; on each accepting edge the pair moves to the scoreboard.
  initial forever begin
    @(negedge BCLK);
    #1;
    if (src_q.size() > 0) begin
      sampleValid = 1'b1;
      {leftSample, rightSample} = src_q[0];
    end else begin
      sampleValid = 1'b0;
    end
    @(posedge BCLK);
    if (sampleValid && sampleReady && !RESET) begin
      exp_q.push_back(src_q.pop_front());
    end
  end

  task automatic check_half(input string name, input int half, input logic [W-1:0] val);
    for (int i = 0; i < half; i++) begin
      logic exp_bit;
      if (i > 0) begin
        @(posedge BCLK);
        #1;
      end
      exp_bit = (i < W) ? val[W-1-i] : 1'b0;
      checks++;
      if (DACDAT !== exp_bit) begin
        errors++;
        $display("FAIL %s bit %0d: DACDAT=%b expected %b", name, i, DACDAT, exp_bit);
      end
    end
  endtask

  task automatic run_frame(input int half, input bit bypass, input logic [2*W-1:0] bp);
    logic [W-1:0] el, er;
    logic         eu;
    @(negedge BCLK);
    DACLRCK = 1'b1;
    if (bypass) src_q.push_back(bp);
    @(posedge BCLK);
    #1;
    eu = (exp_q.size() == 0);
    if (eu) begin
`ifdef SERIALIZER_UNDERRUN_ZERO_EN
      el = '0;
      er = '0;
`else
      el = last_l;
      er = last_r;
`endif
    end else begin
      {el, er} = exp_q.pop_front();
    end
    last_l = el;
    last_r = er;
    rdy_at_start = sampleReady;
    checks++;
    if (underrun !== eu) begin
      errors++;
      $display("FAIL underrun_at_start: underrun=%b expected %b", underrun, eu);
    end
    check_half("left", half, el);
    @(negedge BCLK);
    DACLRCK = 1'b0;
    @(posedge BCLK);
    #1;
    check_half("right", half, er);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    #12;
    checks += 3;
    if (DACDAT !== 1'b0)      begin errors++; $display("FAIL reset_dacdat: %b expected 0", DACDAT); end
    if (underrun !== 1'b0)    begin errors++; $display("FAIL reset_underrun: %b expected 0", underrun); end
    if (sampleReady !== 1'b1) begin errors++; $display("FAIL reset_ready: %b expected 1", sampleReady); end
    @(negedge BCLK);
    RESET = 1'b0;
    repeat (3) @(posedge BCLK);
    #1;
    checks++;
    if (DACDAT !== 1'b0) begin errors++; $display("FAIL idle_dacdat: %b expected 0", DACDAT); end
  endtask

  task automatic test_basic;
    src_q.push_back({16'hA5C3, 16'h8001});
    repeat (4) @(posedge BCLK);
    #1;
    checks++;
    if (sampleReady !== 1'b0) begin errors++; $display("FAIL basic_buffered_ready: %b expected 0", sampleReady); end
    run_frame(16, 1'b0, '0);
  endtask

  task automatic test_underrun;
    run_frame(16, 1'b0, '0);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_after: %b expected 0", underrun); end
  endtask

  task automatic test_back_to_back;
    src_q.push_back({16'h1111, 16'h2222});
    src_q.push_back({16'h3333, 16'h4444});
    repeat (5) @(posedge BCLK);
    #1;
    checks += 2;
    if (sampleReady !== 1'b0) begin errors++; $display("FAIL bp_ready_held: %b expected 0", sampleReady); end
    if (src_q.size() != 1)    begin errors++; $display("FAIL bp_pending: %0d pairs expected 1", src_q.size()); end
    run_frame(16, 1'b0, '0);
    checks++;
    if (rdy_at_start !== 1'b1) begin errors++; $display("FAIL bp_ready_after_start: %b expected 1", rdy_at_start); end
    run_frame(16, 1'b0, '0);
  endtask

  task automatic test_bypass;
    run_frame(16, 1'b1, {16'h7FFF, 16'h8000});
    checks++;
    if (rdy_at_start !== 1'b1) begin errors++; $display("FAIL bypass_ready: %b expected 1", rdy_at_start); end
  endtask

  task automatic test_half_length;
    src_q.push_back({16'hF00F, 16'h0FF1});
    repeat (4) @(posedge BCLK);
    run_frame(24, 1'b0, '0);
    src_q.push_back({16'hBEEF, 16'hC0DE});
    repeat (4) @(posedge BCLK);
    run_frame(12, 1'b0, '0);
    src_q.push_back({16'h9ABC, 16'hDEF1});
    repeat (4) @(posedge BCLK);
    run_frame(16, 1'b0, '0);
  endtask

  task automatic test_reset_mid;
    src_q.push_back({16'hFFFF, 16'hFFFF});
    repeat (4) @(posedge BCLK);
    @(negedge BCLK);
    DACLRCK = 1'b1;
    @(posedge BCLK);
    #1;
    void'(exp_q.pop_front());
    repeat (3) @(posedge BCLK);
    #1;
    checks++;
    if (DACDAT !== 1'b1) begin errors++; $display("FAIL mid_before_reset: %b expected 1", DACDAT); end
    #1;
    RESET = 1'b1;
    #1;
    checks += 2;
    if (DACDAT !== 1'b0)      begin errors++; $display("FAIL mid_reset_dacdat: %b expected 0", DACDAT); end
    if (sampleReady !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: %b expected 1", sampleReady); end
    last_l = '0;
    last_r = '0;
    repeat (2) @(negedge BCLK);
    RESET = 1'b0;
    repeat (3) @(negedge BCLK);
    DACLRCK = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge BCLK);
      #1;
      checks++;
      if (DACDAT !== 1'b0) begin errors++; $display("FAIL mid_ignored cycle %0d: DACDAT=%b expected 0", i, DACDAT); end
    end
    src_q.push_back({16'h1234, 16'hABCD});
    repeat (4) @(posedge BCLK);
    run_frame(16, 1'b0, '0);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_underrun;
    test_back_to_back;
    test_bypass;
    test_half_length;
    test_reset_mid;
    repeat (4) @(posedge BCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Transmit-side counterpart of the ADC deserializer. Takes a stereo pair of signed 16-bit samples and shifts them out MSB-first on DACDAT.
- Framing comes from the codec-driven DACLRCK; the block is clocked directly by BCLK.
- Sits between the effects chain output and the audio codec DAC pins.
- A one-entry holding buffer with valid/ready decouples the effects chain from frame timing.

Parameters:
- SAMPLE_W, 16, bits per channel sample.
- LEFT_LEVEL, 1, DACLRCK level that denotes the left half. The transition into this level is the frame start.

Ports:
- BCLK  input  1  bit clock from codec; the only clock; all logic on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- DACLRCK  input  1  frame/channel clock from codec.
- leftSample  input  SAMPLE_W  signed left sample.
- rightSample  input  SAMPLE_W  signed right sample.
- sampleValid  input  1  sample pair presented.
- sampleReady  output  1  buffer can accept; equals !bufFull.
- DACDAT  output  1  registered serial data to codec.
- underrun  output  1  one-cycle pulse when a frame starts with no fresh sample.

Behaviour:
- Reset values: DACDAT=0, underrun=0, bufFull=0 (so sampleReady=1), shift register=0, last-sent pair=0, bit counter=0, state=SYNC.
- Reset is asynchronous. Asserting it mid-frame abandons the frame immediately.
- Edge detect: lrPrev is a registered copy of DACLRCK.
  - startEdge = DACLRCK==LEFT_LEVEL && lrPrev!=LEFT_LEVEL.
  - midEdge = DACLRCK!=LEFT_LEVEL && lrPrev==LEFT_LEVEL.
- Handshake: a pair is accepted on a rising BCLK when sampleValid && sampleReady. Accepted pair goes into bufL/bufR and sets bufFull. sampleReady is combinational from bufFull.
- States:
  - SYNC: DACDAT=0. Ignore midEdge. On startEdge, go to LEFT.
  - LEFT: on midEdge, go to RIGHT. On startEdge, restart LEFT with a new frame load.
  - RIGHT: on startEdge, go to LEFT with a new frame load. A midEdge in RIGHT cannot occur.
- Frame load (on any startEdge), choose the pair to send:
  - bufFull=1: send buf; clear bufFull, so sampleReady=1 on the next cycle.
  - bufFull=0 and a pair is accepted in the same cycle: send the incoming pair directly (bypass). bufFull stays 0 and underrun stays 0.
  - bufFull=0 and no accept: send the last-sent pair and pulse underrun for exactly one cycle.
  - The chosen pair goes into the shift register and last-sent register. DACDAT <= left MSB; counter <= 1.
- Half start on midEdge: DACDAT <= right MSB; counter <= 1.
- Other cycles in LEFT/RIGHT:
  - counter < SAMPLE_W: DACDAT <= next bit MSB-first; counter++.
  - Otherwise DACDAT <= 0 as padding; counter saturates.
- Latency: the MSB is driven on the same rising edge that detects the DACLRCK transition. The codec therefore sees the MSB one BCLK after the transition (I2S-style delay).
- Short halves (fewer than SAMPLE_W BCLKs): remaining bits are dropped and the next edge starts cleanly.
- Long halves: padding is 0.

Optional Feature:
- Macro: SERIALIZER_UNDERRUN_ZERO_EN.
- Defined: an underrun frame sends 0 on both channels, and last-sent is updated to 0.
- Not defined: an underrun frame repeats the last-sent pair.
- The underrun pulse behaves identically in both cases.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W constant.
  - typedef sample_t = logic signed [SAMPLE_W-1:0].
  - ser_state_t enum {SYNC, LEFT, RIGHT}.
- One natural sub-module: lrck_edge. It registers lrPrev and outputs startEdge/midEdge given LEFT_LEVEL; it can be reused by the deserializer.

Test Plan:
- Reset, then accept L=16'hA5C3, R=16'h8001, with 16 BCLK per half. Required response:
  - DACDAT = 1010010111000011 starting on the startEdge cycle.
  - Then 1000000000000001 starting on the midEdge cycle.
  - underrun=0.
- No new sample before the second frame:
  - underrun high exactly one cycle at startEdge.
  - Frame repeats A5C3/8001; with SERIALIZER_UNDERRUN_ZERO_EN, 0000/0000.
- Backpressure: hold sampleValid with pairs 1111/2222 then 3333/4444.
  - sampleReady=0 after the first accept until the startEdge.
  - Second pair accepted the cycle after the startEdge and sent in the following frame.
- Buffer empty and sampleValid with 7FFF/8000 arriving exactly on the startEdge cycle:
  - 7FFF sent in that frame (bypass).
  - bufFull stays 0, underrun=0.
- 24 BCLK per half: bits 17–24 of each half DACDAT=0. 12 BCLK per half: only the top 12 bits of each half are sent, and the next half's MSB is correct.
- RESET asserted mid-LEFT:
  - DACDAT=0 immediately (asynchronous); sampleReady=1.
  - Following midEdge ignored; transmission resumes only at the next startEdge.
